// File: rtl/unaligned_dp_sram_pkg.sv
// Shared types, default geometry and the byte-lane mask helper for unaligned_dp_sram.
package unaligned_dp_sram_pkg;

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  localparam int DEFAULT_BITWIDTH = 32;
  localparam int DEFAULT_ENTRIES  = 512;
  localparam int BPW = DEFAULT_BITWIDTH / 8;
  localparam int OW  = $clog2(BPW);
  localparam int AW  = $clog2(DEFAULT_ENTRIES);
  localparam int MAX_BPW = 64;

  // Word-lane mask (MSB = byte 0) touched by the first (half=0) or second (half=1)
  // word of an access starting at byte `offset`; byteEnable is MSB = first access byte.
  function automatic logic [MAX_BPW-1:0] laneMask(input int offset,
                                                  input logic [MAX_BPW-1:0] byteEnable,
                                                  input logic half,
                                                  input int bpw);
    logic [MAX_BPW-1:0] mask;
    mask = '0;
    for (int j = 0; j < MAX_BPW; j++) begin
      if (j < bpw) begin
        if (!half && j >= offset)
          mask[bpw-1-j] = byteEnable[bpw-1-j+offset];
        else if (half && j < offset)
          mask[bpw-1-j] = byteEnable[offset-1-j];
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/unaligned_dp_sram_byte_lane_rotator.sv
// Combinational byte rotation toward the MSB: output byte j = input byte (j+amount) mod bytes.
module byte_lane_rotator #(
  parameter int WIDTH = 32,
  parameter int SW    = 2
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    amount,
  output logic [WIDTH-1:0] rotated
);
  localparam int NB = WIDTH / 8;

  always_comb begin
    int src;
    src = 0;
    rotated = '0;
    for (int i = 0; i < NB; i++) begin
      src = (i + NB - int'(amount)) % NB;
      rotated[8*i +: 8] = data[8*src +: 8];
    end
  end

endmodule

// File: rtl/unaligned_dp_sram.sv
// Dual-port byte-enabled SRAM; port A handles unaligned/straddling accesses, port B is aligned.
// Optional collision counter output enabled by UNALIGNED_DP_SRAM_COLLISION_COUNT_EN.
module unaligned_dp_sram
  import unaligned_dp_sram_pkg::*;
#(
  parameter int bitwidth    = DEFAULT_BITWIDTH,
  parameter int nrOfEntries = DEFAULT_ENTRIES,
  localparam int BYTES = bitwidth / 8,
  localparam int OFFW  = (BYTES > 1) ? $clog2(BYTES) : 1,
  localparam int ADDRW = $clog2(nrOfEntries)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                aStart,
  input  logic                aWrite,
  input  logic [ADDRW-1:0]    aAddress,
  input  logic [OFFW-1:0]     aOffset,
  input  logic [BYTES-1:0]    aByteEnable,
  input  logic [bitwidth-1:0] aDataIn,
  output logic                aBusy,
  output logic                aDone,
  output logic [bitwidth-1:0] aDataOut,
  input  logic                bWriteEnable,
  input  logic [BYTES-1:0]    bByteEnable,
  input  logic [ADDRW-1:0]    bAddress,
  input  logic [bitwidth-1:0] bDataIn,
  output logic [bitwidth-1:0] bDataOut
`ifdef UNALIGNED_DP_SRAM_COLLISION_COUNT_EN
  ,
  output logic [15:0]         collisionCount
`endif
);

  logic [bitwidth-1:0] mem [nrOfEntries];

  state_t              state;
  logic [ADDRW-1:0]    cap_addr;
  logic [OFFW-1:0]     cap_off;
  logic [BYTES-1:0]    cap_mask;
  logic [bitwidth-1:0] cap_wdata;
  logic [bitwidth-1:0] first_word;

  logic [OFFW-1:0]     wr_rot;
  logic [bitwidth-1:0] wdata_rot;
  logic [BYTES-1:0]    mask_first;
  logic [BYTES-1:0]    mask_second;
  logic [ADDRW-1:0]    next_addr;

  logic [ADDRW-1:0]    a_addr;
  logic [BYTES-1:0]    a_mask;
  logic [bitwidth-1:0] a_wdata;
  logic [bitwidth-1:0] a_new;
  logic [BYTES-1:0]    b_mask;
  logic [bitwidth-1:0] b_new;
  logic [bitwidth-1:0] rd_merged;
  logic [bitwidth-1:0] rd_word;

  assign aBusy = (state == SECOND);

  // Rotating by -offset places access byte 0 at word byte `offset`.
  assign wr_rot = -aOffset;

  byte_lane_rotator #(.WIDTH(bitwidth), .SW(OFFW)) u_wr_rot (
    .data    (aDataIn),
    .amount  (wr_rot),
    .rotated (wdata_rot)
  );

  assign mask_first  = BYTES'(laneMask(int'(aOffset), MAX_BPW'(aByteEnable), 1'b0, BYTES));
  assign mask_second = BYTES'(laneMask(int'(aOffset), MAX_BPW'(aByteEnable), 1'b1, BYTES));
  assign next_addr   = (aAddress == ADDRW'(nrOfEntries - 1)) ? '0 : aAddress + 1'b1;

  always_comb begin
    a_addr  = aAddress;
    a_mask  = '0;
    a_wdata = wdata_rot;
    if (state == SECOND) begin
      a_addr  = cap_addr;
      a_mask  = cap_mask;
      a_wdata = cap_wdata;
    end else if (aStart && aWrite) begin
      a_mask = mask_first;
    end
    // A reset edge must not commit any port A lanes (aborts the second half).
    if (reset)
      a_mask = '0;
  end

  assign b_mask = bWriteEnable ? bByteEnable : '0;

  // Each port sees its own write (write-first) merged over the pre-edge contents.
  always_comb begin
    a_new = mem[a_addr];
    b_new = mem[bAddress];
    for (int i = 0; i < BYTES; i++) begin
      if (a_mask[i])
        a_new[8*i +: 8] = a_wdata[8*i +: 8];
      if (b_mask[i])
        b_new[8*i +: 8] = bDataIn[8*i +: 8];
    end
  end

  always_comb begin
    rd_merged = '0;
    for (int i = 0; i < BYTES; i++)
      rd_merged[8*i +: 8] = (i < BYTES - int'(cap_off)) ? first_word[8*i +: 8] : a_new[8*i +: 8];
  end

  byte_lane_rotator #(.WIDTH(bitwidth), .SW(OFFW)) u_rd_rot (
    .data    (rd_merged),
    .amount  (cap_off),
    .rotated (rd_word)
  );

  // Port A is applied after port B so it wins on doubly-written bytes.
  always_ff @(posedge clock) begin
    for (int i = 0; i < BYTES; i++) begin
      if (b_mask[i])
        mem[bAddress][8*i +: 8] <= bDataIn[8*i +: 8];
      if (a_mask[i])
        mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      aDone    <= 1'b0;
      aDataOut <= '0;
      bDataOut <= '0;
    end else begin
      aDone    <= 1'b0;
      bDataOut <= b_new;
      case (state)
        IDLE: begin
          if (aStart) begin
            if (aOffset == '0) begin
              aDataOut <= a_new;
              aDone    <= 1'b1;
            end else begin
              state      <= SECOND;
              first_word <= a_new;
              cap_addr   <= next_addr;
              cap_off    <= aOffset;
              cap_mask   <= aWrite ? mask_second : '0;
              cap_wdata  <= wdata_rot;
            end
          end
        end
        SECOND: begin
          aDataOut <= rd_word;
          aDone    <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UNALIGNED_DP_SRAM_COLLISION_COUNT_EN
  logic collide;
  assign collide = (a_addr == bAddress) && |(a_mask & b_mask);

  always_ff @(posedge clock) begin
    if (reset)
      collisionCount <= '0;
    else if (collide && collisionCount != 16'hFFFF)
      collisionCount <= collisionCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_unaligned_dp_sram.sv
// Randomized + directed bench for unaligned_dp_sram against a byte-linear memory model.
module tb_unaligned_dp_sram;
  localparam int NW  = 512;
  localparam int TOT = NW * 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        aStart, aWrite;
  logic [8:0]  aAddress;
  logic [1:0]  aOffset;
  logic [3:0]  aByteEnable;
  logic [31:0] aDataIn;
  logic        aBusy, aDone;
  logic [31:0] aDataOut;
  logic        bWriteEnable;
  logic [3:0]  bByteEnable;
  logic [8:0]  bAddress;
  logic [31:0] bDataIn;
  logic [31:0] bDataOut;
`ifdef UNALIGNED_DP_SRAM_COLLISION_COUNT_EN
  logic [15:0] collisionCount;
`endif

  unaligned_dp_sram #(.bitwidth(32), .nrOfEntries(NW)) dut (
    .clock        (clock),
    .reset        (reset),
    .aStart       (aStart),
    .aWrite       (aWrite),
    .aAddress     (aAddress),
    .aOffset      (aOffset),
    .aByteEnable  (aByteEnable),
    .aDataIn      (aDataIn),
    .aBusy        (aBusy),
    .aDone        (aDone),
    .aDataOut     (aDataOut),
    .bWriteEnable (bWriteEnable),
    .bByteEnable  (bByteEnable),
    .bAddress     (bAddress),
    .bDataIn      (bDataIn),
    .bDataOut     (bDataOut)
`ifdef UNALIGNED_DP_SRAM_COLLISION_COUNT_EN
    ,
    .collisionCount (collisionCount)
`endif
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: memory as a flat big-endian byte array; an access covers consecutive global bytes.
  logic [7:0]  mm [TOT];
  logic        m_busy = 1'b0;
  int          p_addr, p_off;
  logic        p_we;
  logic [3:0]  p_be;
  logic [31:0] p_din, p_rd;
  logic        exp_busy, exp_done;
  logic [31:0] exp_a, exp_b;
  int          exp_coll;

  always @(posedge clock) begin : model
    int g;
    int a_g [4];
    logic [3:0] a_wr;
    logic do_a, second, coll;
    if (reset) begin
      m_busy = 0; exp_busy = 0; exp_done = 0; exp_a = 0; exp_b = 0; exp_coll = 0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        g = int'(bAddress) * 4 + j;
        exp_b[31-8*j -: 8] = (bWriteEnable && bByteEnable[3-j]) ? bDataIn[31-8*j -: 8] : mm[g];
      end
      do_a = 0; second = 0;
      if (m_busy) begin
        do_a = 1; second = 1;
      end else if (aStart) begin
        do_a = 1;
        p_addr = int'(aAddress); p_off = int'(aOffset);
        p_we = aWrite; p_be = aByteEnable; p_din = aDataIn;
      end
      a_wr = '0;
      for (int i = 0; i < 4; i++) begin
        a_g[i] = (p_addr * 4 + p_off + i) % TOT;
        if (do_a && (((p_off + i) >= 4) == second)) begin
          if (p_we && p_be[3-i]) begin
            a_wr[i] = 1'b1;
            p_rd[31-8*i -: 8] = p_din[31-8*i -: 8];
          end else begin
            p_rd[31-8*i -: 8] = mm[a_g[i]];
          end
        end
      end
      coll = 0;
      for (int i = 0; i < 4; i++)
        if (a_wr[i] && bWriteEnable && (a_g[i] / 4 == int'(bAddress)) && bByteEnable[3 - a_g[i] % 4])
          coll = 1;
      for (int j = 0; j < 4; j++)
        if (bWriteEnable && bByteEnable[3-j]) mm[int'(bAddress) * 4 + j] = bDataIn[31-8*j -: 8];
      for (int i = 0; i < 4; i++)
        if (a_wr[i]) mm[a_g[i]] = p_din[31-8*i -: 8];
      if (coll && exp_coll < 65535) exp_coll++;
      exp_done = 0;
      if (do_a) begin
        if (second || p_off == 0) begin
          exp_done = 1; exp_a = p_rd; m_busy = 0;
        end else begin
          m_busy = 1;
        end
      end
      exp_busy = m_busy;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", 32'(aBusy), 32'(exp_busy));
      chk("done", 32'(aDone), 32'(exp_done));
      if (exp_done) chk("a_data", aDataOut, exp_a);
      chk("b_data", bDataOut, exp_b);
`ifdef UNALIGNED_DP_SRAM_COLLISION_COUNT_EN
      chk("coll_count", 32'(collisionCount), 32'(exp_coll));
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic a_issue(input int addr, input int off, input logic we, input logic [3:0] be,
                         input logic [31:0] din);
    aStart = 1'b1; aWrite = we; aAddress = 9'(addr); aOffset = 2'(off);
    aByteEnable = be; aDataIn = din;
  endtask

  task automatic bwrite(input int addr, input logic [31:0] d);
    bWriteEnable = 1'b1; bByteEnable = 4'hF; bAddress = 9'(addr); bDataIn = d;
    step();
    bWriteEnable = 1'b0;
  endtask

  task automatic bread(input int addr, output logic [31:0] v);
    bWriteEnable = 1'b0; bAddress = 9'(addr);
    step();
    v = bDataOut;
  endtask

  function automatic int pick_addr();
    int r;
    r = int'($urandom_range(0, 19));
    return (r < 16) ? r : 492 + r;
  endfunction

  initial begin
    logic [31:0] v;
    reset = 1'b1; aStart = 0; aWrite = 0; aAddress = 0; aOffset = 0; aByteEnable = 0; aDataIn = 0;
    bWriteEnable = 0; bByteEnable = 0; bAddress = 0; bDataIn = 0;
    step();
    chk_en = 1'b1;
    chk("rst_busy", 32'(aBusy), 32'h0);
    chk("rst_done", 32'(aDone), 32'h0);
    chk("rst_adata", aDataOut, 32'h0);
    chk("rst_bdata", bDataOut, 32'h0);
    step();
    reset = 1'b0;

    for (int w = 0; w < NW; w++) bwrite(w, $urandom);

    // Aligned round trip
    a_issue(5, 0, 1, 4'hF, 32'hDEADBEEF); step(); aStart = 0;
    chk("t1_done", 32'(aDone), 32'h1);
    chk("t1_wdata", aDataOut, 32'hDEADBEEF);
    a_issue(5, 0, 0, 4'hF, 32'h0); bAddress = 9'd5; step(); aStart = 0;
    chk("t1_rd_a", aDataOut, 32'hDEADBEEF);
    chk("t1_rd_b", bDataOut, 32'hDEADBEEF);

    // Straddling write at offset 1
    bwrite(7, 32'h11223344); bwrite(8, 32'h55667788);
    a_issue(7, 1, 1, 4'hF, 32'hAABBCCDD); step(); aStart = 0;
    chk("t2_busy", 32'(aBusy), 32'h1);
    chk("t2_nodone", 32'(aDone), 32'h0);
    step();
    chk("t2_done", 32'(aDone), 32'h1);
    chk("t2_busy_clr", 32'(aBusy), 32'h0);
    chk("t2_wdata", aDataOut, 32'hAABBCCDD);
    bread(7, v); chk("t2_mem7", v, 32'h11AABBCC);
    bread(8, v); chk("t2_mem8", v, 32'hDD667788);
    a_issue(7, 1, 0, 4'hF, 32'h0); step(); aStart = 0; step();
    chk("t2_rdback", aDataOut, 32'hAABBCCDD);

    // Wrap from the last word to word 0
    a_issue(511, 3, 1, 4'hF, 32'h01020304); step(); aStart = 0; step();
    bread(511, v); chk("t3_mem511", 32'(v[7:0]), 32'h01);
    bread(0, v);   chk("t3_mem0", 32'(v[31:8]), 32'h020304);
    a_issue(511, 3, 0, 4'hF, 32'h0); step(); aStart = 0; step();
    chk("t3_rdback", aDataOut, 32'h01020304);

    // Same-edge write collision on word 3
    bwrite(3, 32'h12345678);
    a_issue(3, 0, 1, 4'b1100, 32'hFFFFFFFF);
    bWriteEnable = 1'b1; bByteEnable = 4'b0110; bAddress = 9'd3; bDataIn = 32'h0;
    step(); aStart = 0; bWriteEnable = 0;
`ifdef UNALIGNED_DP_SRAM_COLLISION_COUNT_EN
    chk("t4_count", 32'(collisionCount), 32'h1);
`endif
    bread(3, v); chk("t4_mem3", v, 32'hFFFF0078);

    // aStart while busy is dropped; aStart alongside aDone is taken
    a_issue(10, 2, 0, 4'hF, 32'h0); step();
    chk("t5_busy", 32'(aBusy), 32'h1);
    a_issue(5, 0, 0, 4'hF, 32'h0); step();
    chk("t5_done1", 32'(aDone), 32'h1);
    chk("t5_idle", 32'(aBusy), 32'h0);
    step(); aStart = 0;
    chk("t5_done2", 32'(aDone), 32'h1);
    chk("t5_data2", aDataOut, 32'hDEADBEEF);
    step();
    chk("t5_no_extra", 32'(aDone), 32'h0);

    // Reset during the second half of a split write
    bwrite(20, 32'hA1A2A3A4); bwrite(21, 32'hB1B2B3B4);
    a_issue(20, 2, 1, 4'hF, 32'hC1C2C3C4); step(); aStart = 0;
    chk("t6_busy", 32'(aBusy), 32'h1);
    reset = 1'b1; step();
    chk("t6_busy_rst", 32'(aBusy), 32'h0);
    chk("t6_done_rst", 32'(aDone), 32'h0);
    reset = 1'b0; step();
    chk("t6_no_done", 32'(aDone), 32'h0);
    bread(20, v); chk("t6_mem20", v, 32'hA1A2C1C2);
    bread(21, v); chk("t6_mem21", v, 32'hB1B2B3B4);

    // Random traffic on a small address window including the wrap boundary
    for (int c = 0; c < 3000; c++) begin
      aStart = 1'($urandom_range(0, 1));
      aWrite = 1'($urandom_range(0, 1));
      aAddress = 9'(pick_addr());
      aOffset = 2'($urandom_range(0, 3));
      aByteEnable = 4'($urandom);
      aDataIn = $urandom;
      bWriteEnable = 1'($urandom_range(0, 1));
      bByteEnable = 4'($urandom);
      bAddress = 9'(pick_addr());
      bDataIn = $urandom;
      step();
    end
    aStart = 0; bWriteEnable = 0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/unaligned_dp_sram.md
Name: unaligned_dp_sram

Overview:
Single-clock, parametrised dual-port synchronous SRAM with byte-lane write enables. Port A accepts word accesses at any byte offset, including accesses that straddle two words, through a start/busy/done handshake. Port B is a plain aligned port that is always ready. It is the generalised data-buffer memory for the ramDmaCi custom-instruction/DMA path: port A is the CPU side and port B is the DMA side.

Parameters:
bitwidth, 32, word width in bits; a multiple of 8, ≥16; bytes per word (BPW = bitwidth/8) must be a power of two
nrOfEntries, 512, number of words; AW = $clog2(nrOfEntries), OW = $clog2(BPW)

Ports:
clock  in  1  single clock; everything samples on the rising edge
reset  in  1  synchronous, active-high
aStart  in  1  port A request; accepted only in a cycle where aBusy=0
aWrite  in  1  1 = write, 0 = read (sampled with aStart)
aAddress  in  AW  word address of the first byte
aOffset  in  OW  byte offset within that word
aByteEnable  in  BPW  per-byte write enable of the access; MSB = first (lowest-address) byte
aDataIn  in  bitwidth  write data; MSB byte = first byte
aBusy  out  1  high while the second half of a split access is pending
aDone  out  1  one-cycle pulse; aDataOut is valid in this cycle
aDataOut  out  bitwidth  read data, or merged post-write data for writes
bWriteEnable  in  1  port B write
bByteEnable  in  BPW  port B byte enables, MSB = byte 0
bAddress  in  AW  port B word address
bDataIn  in  bitwidth  port B write data
bDataOut  out  bitwidth  port B registered read data

Behaviour:
- Byte order is big-endian: byte 0 of a word is bits [bitwidth-1 -: 8].
- An access at offset k covers bytes k..BPW-1 of word aAddress, then bytes 0..k-1 of word aAddress+1 (addition modulo nrOfEntries, so address nrOfEntries-1 wraps to 0).
- Reset:
  - aBusy, aDone, aDataOut and bDataOut go to 0; the FSM goes to IDLE.
  - Memory contents are not cleared.
  - Reset during SECOND aborts the access: the first word stays written, the second word is untouched, and no aDone is produced.
- FSM states: IDLE, SECOND.
  - IDLE, aStart, aOffset=0: access the single word at the end of cycle T; aDone=1 in T+1; stay in IDLE.
  - IDLE, aStart, aOffset≠0: capture the operands; access the first-word lanes at the end of T; go to SECOND with aBusy=1 in T+1; access the second-word lanes at the end of T+1; aDone=1 in T+2; return to IDLE.
  - aStart while aBusy=1 is ignored (not queued).
  - aStart in a cycle with aDone=1 and aBusy=0 is accepted, giving back-to-back throughput.
- Port A writes update only the bytes whose aByteEnable bit is set. aDataOut returns the word as it is after the write (write-first).
- Port B: read latency 1 (bDataOut valid the cycle after the address). Byte-enabled writes, write-first on its own address. No handshake.
- Cross-port collisions, same word on the same edge:
  - Both ports write: per byte, port A wins where both enable that byte; bytes enabled only by B take B's data.
  - One port reads while the other writes: the reader gets the old data.

Optional Feature:
UNALIGNED_DP_SRAM_COLLISION_COUNT_EN
- Defined: adds output collisionCount (16 bits, saturating, reset to 0). It increments by 1 each edge where both ports write at least one common byte of the same word.
- Undefined: the port does not exist and no counter logic is built.

Decomposition:
- Package unaligned_dp_sram_pkg holds:
  - the state typedef (IDLE, SECOND)
  - localparams BPW, OW, AW
  - function laneMask(offset, byteEnable, half), which returns the per-word byte mask for the first or second half of an access
- One sub-module, byte_lane_rotator: purely combinational rotation by aOffset bytes. It is used for write-data alignment and for read-data reassembly.

Test Plan:
- Aligned round trip, bitwidth=32: write 0xDEADBEEF at addr 5, offset 0, BE=1111 → aDone one cycle later. Read addr 5 → aDataOut=0xDEADBEEF; on port B, bAddress=5 → 0xDEADBEEF.
- Unaligned split: preload mem[7]=0x11223344 and mem[8]=0x55667788. Write 0xAABBCCDD at addr 7, offset 1, BE=1111 → aBusy=1 for one cycle, aDone at T+2, mem[7]=0x11AABBCC, mem[8]=0xDD667788. Read at the same address/offset → 0xAABBCCDD.
- Wrap-around: access at addr 511, offset 3, nrOfEntries=512 → second half touches mem[0]. Read after writing 0x01020304 → mem[511] byte 3 = 0x01 and mem[0][31:8] = 0x020304.
- Collision: same edge, A writes 0xFFFFFFFF with BE=1100 and B writes 0x00000000 with BE=0110 to word 3 → mem[3] bytes = FF, FF, 00, old byte 3. With the macro defined, collisionCount=1.
- Busy handling: aStart asserted during SECOND → ignored, exactly one aDone. aStart together with aDone → accepted, and the next aDone arrives as expected.
- Reset mid-operation: assert reset during SECOND of an offset-2 write → mem[addr] is updated, mem[addr+1] is unchanged, aDone stays 0, aBusy=0 after reset.
